ring_agent_p: RTL
=================

RING_AGENT_P -- requirements
Module: ring_agent_p

Interface
REQ-001 Parameter MSGW, default 160, message width in bits; legal range 32 or more.
REQ-002 Parameter RXDEPTH, default 4, depth of the local receive FIFO.
REQ-003 Parameter TXDEPTH, default 4, depth of the local inject FIFO.
REQ-004 Parameter FWDDEPTH, default 2, depth of the pass-through FIFO.
REQ-005 Parameter MAXHOPS, default 16, hop limit; a message reaching it is dropped.
REQ-006 Parameter STARVE, default 4, maximum consecutive forward loads while injection waits.
REQ-007 Parameter DROP_ON_FULL, default 0; 1 accepts and discards local messages when the RX FIFO is full.
REQ-008 Ports (name direction width meaning) SHALL be: clk in 1 clock; rst_n in 1 async active-low reset; en in 1 ring enable; localid in 8 node id (0 reserved); msgin in MSGW upstream message; okout out 1 accept pulse to upstream; msgout out MSGW downstream message; okin in 1 accept pulse from downstream; tx_data in MSGW inject data; tx_vld in 1; tx_rdy out 1; rx_data out MSGW; rx_vld out 1; rx_rdy in 1; busy out 1; drops out 16 drop count.
REQ-009 The design SHALL use one clock, clk, with asynchronous active-low reset rst_n.

Function
REQ-010 Header fields: [7:0] dest, [15:8] src, [23:16] hop, [31:24] tag; a message is valid iff bits [31:0] are nonzero.
REQ-011 Input accept occurs in a cycle when en=1, msgin valid, okout=0, and the target store has room, judged on registered full flags.
REQ-012 Target store: RX FIFO if dest==localid, otherwise FWD FIFO.
REQ-013 okout SHALL be a registered single-cycle pulse in the cycle after accept; msgin is not sampled while okout=1, giving one message per 2 cycles.
REQ-014 On forward accept, hop is incremented; if the new hop equals MAXHOPS the message is discarded, still acknowledged, and drops is incremented.
REQ-015 Local message with RX full: DROP_ON_FULL=0 gives no accept (backpressure); DROP_ON_FULL=1 accepts, discards, and increments drops.
REQ-016 drops SHALL saturate at 16'hFFFF.
REQ-017 The output slot holds msgout stable until okin=1 is sampled; it reloads in that same edge, or whenever the slot is empty, and becomes zero if nothing is pending.
REQ-018 Load priority is the FWD head, except when TX is non-empty and the starve counter equals STARVE; then the TX head is loaded.
REQ-019 The starve counter increments on each forward load while TX is non-empty, and clears on an inject load or when TX is empty.
REQ-020 On inject load, src=localid and hop=0 are overwritten; other bits pass unchanged. A dest==localid message circulates the ring and is consumed on return.
REQ-021 TX push occurs on tx_vld&tx_rdy, with tx_rdy = TX not full; it is independent of en.
REQ-022 RX is first-word-fall-through: rx_vld = non-empty, rx_data = head, pop on rx_vld&rx_rdy; it is independent of en.
REQ-023 Simultaneous push and pop on a full FIFO SHALL pop only in that cycle; the push is refused.
REQ-024 en=0: no accepts, okout=0, msgout held, starve counter frozen, and a pending okin=1 is ignored.
REQ-025 busy = FWD non-empty | TX non-empty | output slot occupied.

Reset
REQ-026 Reset SHALL be asynchronous and active low; it clears all FIFOs, the output slot, and the starve counter.
REQ-027 Outputs in reset: msgout=0, okout=0, tx_rdy=1 after release, rx_vld=0, busy=0, drops=0.
REQ-028 Reset asserted mid-transfer discards all in-flight messages; no okout pulse follows deassertion.

Verification
REQ-029 Pass-through: localid=8'h51, msgin hdr 32'h01000052 held until okout -> okout at cycle+1; msgout hdr 32'h01010052 two cycles after accept, held until okin.
REQ-030 Local consume: msgin hdr dest=8'h51 -> rx_vld=1 with identical data; msgout remains 0; drops=0.
REQ-031 Hop limit: MAXHOPS=16, incoming hop=15, dest foreign -> okout pulses, no msgout, drops=1.
REQ-032 Starvation: FWD continuously fed, TX holding 1 message, STARVE=4 -> 4 forward loads, then the inject with src=localid, hop=0.
REQ-033 RX full: RXDEPTH=4, rx_rdy=0, 5 local messages -> DROP_ON_FULL=0: 5th gets no okout until a pop; DROP_ON_FULL=1: 5th is acknowledged and drops=1.
REQ-034 Reset mid-hold: msgout nonzero, okin=0, rst_n low 1 cycle -> msgout=0, busy=0, drops=0 immediately (asynchronous).

Source files
------------

// File: rtl/ring_agent_p.sv
// ring_agent_p: slotted-ring node with local receive, inject and pass-through queues.
// Upstream hands over one message per two cycles; the output slot holds until downstream acknowledges.
module ring_agent_p_fifo #(
  parameter int W = 32,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = D > 1 ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);
  localparam logic [AW-1:0] LAST = AW'(D - 1);
  logic [W-1:0] mem [D];
  logic [AW-1:0] rd, wr;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == CW'(D);
  assign empty = cnt == '0;
  // a push against a full queue is refused even when a pop frees a slot that cycle
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rd];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr <= wr == LAST ? '0 : wr + 1'b1;
      if (do_pop) rd <= rd == LAST ? '0 : rd + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
endmodule

module ring_agent_p #(
  parameter int MSGW = 160,
  parameter int RXDEPTH = 4,
  parameter int TXDEPTH = 4,
  parameter int FWDDEPTH = 2,
  parameter int MAXHOPS = 16,
  parameter int STARVE = 4,
  parameter int DROP_ON_FULL = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [7:0]      localid,
  input  logic [MSGW-1:0] msgin,
  output logic            okout,
  output logic [MSGW-1:0] msgout,
  input  logic            okin,
  input  logic [MSGW-1:0] tx_data,
  input  logic            tx_vld,
  output logic            tx_rdy,
  output logic [MSGW-1:0] rx_data,
  output logic            rx_vld,
  input  logic            rx_rdy,
  output logic            busy,
  output logic [15:0]     drops
);
  logic [MSGW-1:0] fwd_din, fwd_head, tx_head, inj;
  logic [7:0] hop_n;
  logic try_in, is_local, hop_drop, rx_push, fwd_push, drop, acc;
  logic rx_full, rx_empty, fwd_full, fwd_empty, tx_full, tx_empty;
  logic occ, ld, ld_tx, ld_fwd;
  logic [15:0] starve;
  assign hop_n = msgin[23:16] + 8'd1;
  assign try_in = en & (|msgin[31:0]) & ~okout;
  assign is_local = msgin[7:0] == localid;
  assign hop_drop = ~is_local & (hop_n == 8'(MAXHOPS));
  assign rx_push = try_in & is_local & ~rx_full;
  assign fwd_push = try_in & ~is_local & ~hop_drop & ~fwd_full;
  assign drop = try_in & (is_local ? rx_full & (DROP_ON_FULL != 0) : hop_drop);
  assign acc = rx_push | fwd_push | drop;
  assign fwd_din = {msgin[MSGW-1:24], hop_n, msgin[15:0]};
  assign inj = {tx_head[MSGW-1:24], 8'd0, localid, tx_head[7:0]};
  assign occ = |msgout[31:0];
  assign ld = en & (~occ | okin);
  // forward traffic wins until the inject queue has waited STARVE loads
  assign ld_tx = ld & ~tx_empty & (fwd_empty | starve == 16'(STARVE));
  assign ld_fwd = ld & ~fwd_empty & ~ld_tx;
  assign tx_rdy = ~tx_full;
  assign rx_vld = ~rx_empty;
  assign busy = ~fwd_empty | ~tx_empty | occ;
  ring_agent_p_fifo #(.W(MSGW), .D(RXDEPTH)) u_rx (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_rdy), .din(msgin),
    .dout(rx_data), .full(rx_full), .empty(rx_empty));
  ring_agent_p_fifo #(.W(MSGW), .D(FWDDEPTH)) u_fwd (
    .clk(clk), .rst_n(rst_n), .push(fwd_push), .pop(ld_fwd), .din(fwd_din),
    .dout(fwd_head), .full(fwd_full), .empty(fwd_empty));
  ring_agent_p_fifo #(.W(MSGW), .D(TXDEPTH)) u_tx (
    .clk(clk), .rst_n(rst_n), .push(tx_vld), .pop(ld_tx), .din(tx_data),
    .dout(tx_head), .full(tx_full), .empty(tx_empty));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      okout <= 1'b0;
      msgout <= '0;
      starve <= '0;
      drops <= '0;
    end else begin
      okout <= acc;
      if (drop && drops != 16'hFFFF) drops <= drops + 16'd1;
      if (ld) msgout <= ld_tx ? inj : ld_fwd ? fwd_head : '0;
      if (en) starve <= (tx_empty || ld_tx) ? '0 : ld_fwd ? starve + 16'd1 : starve;
    end
endmodule
